// File: rtl/acia_pkg.sv
// Shared definitions for the ACIA bus bridge: register map, status/control
// bit positions and the TX feeder state encoding.
package acia_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_RXCNT  = 2'd3;

   localparam int ST_RX_AVAIL = 0;
   localparam int ST_TX_SPACE = 1;
   localparam int ST_RX_OVR   = 2;
   localparam int ST_TX_IDLE  = 3;
   localparam int ST_TX_OVF   = 4;
   localparam int ST_IRQ      = 7;

   localparam int CTRL_RX_IE = 0;
   localparam int CTRL_TX_IE = 1;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_ISSUE = 2'd1,
      TX_WAIT  = 2'd2
   } tx_state_t;

   // Occupancy can reach 256 for the deepest FIFO, which no longer fits a byte.
   function automatic logic [7:0] sat_count(input logic [8:0] c);
      return (c > 9'd255) ? 8'hFF : c[7:0];
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head. Full/empty come from the
// occupancy count; pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_data,
   output logic [WIDTH-1:0]         o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_pop;
   logic             w_do_push;

   // A push into a full FIFO still succeeds when a pop frees a slot that cycle.
   assign w_do_pop  = i_pop & (r_count != '0);
   assign w_do_push = i_push & ((r_count != CW'(DEPTH)) | w_do_pop);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_do_push & ~w_do_pop)      r_count <= r_count + CW'(1);
         else if (w_do_pop & ~w_do_push) r_count <= r_count - CW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/acia_bus_bridge.sv
// CPU-side register bridge for a UART: RX/TX FIFOs, sticky error flags,
// interrupt generation and a feeder FSM that hands TX bytes to the UART.
module acia_bus_bridge
   import acia_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs,
   input  logic       rw,
   input  logic [1:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       irq,
   input  logic       rx_rdy,
   input  logic [7:0] rx_data,
   output logic       ena_tx,
   output logic [7:0] tx_data,
   input  logic       tx_busy
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          w_rd, w_wr, w_clr;
   logic          w_rx_pop, w_rx_full, w_rx_empty, w_rx_ovr_set;
   logic [7:0]    w_rx_head;
   logic [CW-1:0] w_rx_count;
   logic          w_tx_req, w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_ovf_set;
   logic [7:0]    w_tx_head;
   logic [CW-1:0] w_tx_count;
   logic          w_unused_tx_count;
   logic [7:0]    w_status;
   logic          w_irq;
   logic          w_load;
   tx_state_t     r_state, w_next;
   logic [1:0]    r_ctrl;
   logic          r_rx_ovr, r_tx_ovf;
   logic [7:0]    r_dout, r_tx_data;

   assign w_rd     = cs & rw;
   assign w_wr     = cs & ~rw;
   assign w_clr    = w_wr & (addr == ADDR_STATUS);
   assign w_rx_pop = w_rd & (addr == ADDR_DATA);
   assign w_tx_req = w_wr & (addr == ADDR_DATA);

   // A pop in the same cycle makes room, so only an unmatched full push overruns.
   assign w_rx_ovr_set = rx_rdy & w_rx_full & ~w_rx_pop;
   assign w_tx_push    = w_tx_req & ~w_tx_full;
   assign w_tx_ovf_set = w_tx_req & w_tx_full;
   assign w_unused_tx_count = ^w_tx_count;

   sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
      .i_clk   (clk),
      .i_reset (reset),
      .i_push  (rx_rdy),
      .i_pop   (w_rx_pop),
      .i_data  (rx_data),
      .o_head  (w_rx_head),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty),
      .o_count (w_rx_count)
   );

   sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
      .i_clk   (clk),
      .i_reset (reset),
      .i_push  (w_tx_push),
      .i_pop   (w_tx_pop),
      .i_data  (din),
      .o_head  (w_tx_head),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty),
      .o_count (w_tx_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_ovr <= 1'b0;
         r_tx_ovf <= 1'b0;
         r_ctrl   <= 2'b00;
      end else begin
         // Set events take priority over a simultaneous clear.
         r_rx_ovr <= w_rx_ovr_set | (r_rx_ovr & ~(w_clr & din[ST_RX_OVR]));
         r_tx_ovf <= w_tx_ovf_set | (r_tx_ovf & ~(w_clr & din[ST_TX_OVF]));
         if (w_wr && addr == ADDR_CTRL) r_ctrl <= din[1:0];
      end
   end

   assign w_irq = (r_ctrl[CTRL_RX_IE] & ~w_rx_empty) |
                  (r_ctrl[CTRL_TX_IE] & ~w_tx_full) |
                  r_rx_ovr | r_tx_ovf;

   always_comb begin
      w_status              = 8'h00;
      w_status[ST_RX_AVAIL] = ~w_rx_empty;
      w_status[ST_TX_SPACE] = ~w_tx_full;
      w_status[ST_RX_OVR]   = r_rx_ovr;
      w_status[ST_TX_IDLE]  = w_tx_empty & ~tx_busy;
      w_status[ST_TX_OVF]   = r_tx_ovf;
      w_status[ST_IRQ]      = w_irq;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dout <= 8'h00;
      end else if (w_rd) begin
         case (addr)
            ADDR_DATA:   r_dout <= w_rx_empty ? 8'h00 : w_rx_head;
            ADDR_STATUS: r_dout <= w_status;
            ADDR_CTRL:   r_dout <= {6'b000000, r_ctrl};
            default:     r_dout <= sat_count(9'(w_rx_count));
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= TX_IDLE;
         r_tx_data <= 8'h00;
      end else begin
         r_state <= w_next;
         if (w_load) r_tx_data <= w_tx_head;
      end
   end

   // tx_data is captured on entry to ISSUE so it is already valid with ena_tx.
   always_comb begin
      w_next   = r_state;
      w_load   = 1'b0;
      w_tx_pop = 1'b0;
      case (r_state)
         TX_IDLE: begin
            if (!w_tx_empty && !tx_busy) begin
               w_next = TX_ISSUE;
               w_load = 1'b1;
            end
         end
         TX_ISSUE: begin
            w_tx_pop = 1'b1;
            w_next   = TX_WAIT;
         end
         TX_WAIT:  w_next = TX_IDLE;
         default:  w_next = TX_IDLE;
      endcase
   end

   assign ena_tx  = (r_state == TX_ISSUE);
   assign tx_data = r_tx_data;
   assign dout    = r_dout;
   assign irq     = w_irq;

endmodule

// File: doc/acia_bus_bridge.md
ACIA_BUS_BRIDGE -- requirements
Module: acia_bus_bridge

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning entries per RX and TX FIFO (power of 2, 4..256).
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-004 SHALL have port cs, input, 1, a one-cycle bus access strobe.
REQ-005 SHALL have port rw, input, 1, where 1 = read and 0 = write.
REQ-006 SHALL have port addr, input, 2, the register select.
REQ-007 SHALL have port din, input, 8, the CPU write data.
REQ-008 SHALL have port dout, output, 8, the CPU read data, registered.
REQ-009 SHALL have port irq, output, 1, an active-high interrupt request.
REQ-010 SHALL have port rx_rdy, input, 1, a one-clock pulse from the UART when a received byte is valid.
REQ-011 SHALL have port rx_data, input, 8, the UART received byte.
REQ-012 SHALL have port ena_tx, output, 1, a one-clock request to the UART to latch tx_data.
REQ-013 SHALL have port tx_data, output, 8, the byte presented to the UART.
REQ-014 SHALL have port tx_busy, input, 1, UART busy; it rises the cycle after ena_tx.

Function
REQ-015 SHALL decode registers on cs: addr0 read = pop RX data; addr0 write = push TX data; addr1 read = status; addr1 write = clear sticky bits; addr2 read/write = control; addr3 read = RX count.
REQ-016 SHALL load dout on the clock edge where cs&rw is sampled, valid the following cycle; dout holds its value otherwise.
REQ-017 SHALL format status as: bit0 rx_avail (RX not empty), bit1 tx_space (TX not full), bit2 rx_overrun (sticky), bit3 tx_idle (TX empty and tx_busy=0), bit4 tx_overflow (sticky), bit7 irq, others 0.
REQ-018 SHALL define control as: bit0 rx_ie, bit1 tx_ie; other bits read 0.
REQ-019 SHALL, on an addr1 write, clear each sticky bit whose din bit is 1; a set event in the same cycle wins.
REQ-020 SHALL, on an addr0 read with RX empty, return 0x00 and leave the RX count unchanged.
REQ-021 SHALL, on rx_rdy with RX full, drop the byte and set rx_overrun, unless a pop occurs in the same cycle; then both the pop and the push complete and the count is unchanged.
REQ-022 SHALL, on an addr0 write with TX full, drop the byte and set tx_overflow.
REQ-023 SHALL drive TX feeder FSM states IDLE, ISSUE and WAIT:
  - IDLE -> ISSUE when TX is not empty and tx_busy=0.
  - ISSUE: ena_tx=1 for exactly one cycle, tx_data=head, head popped, then -> WAIT.
  - WAIT: one cycle, for tx_busy to rise, then -> IDLE.
REQ-024 SHALL hold tx_data stable from ISSUE until the next ISSUE.
REQ-025 SHALL derive irq combinationally from registered state as (rx_ie & rx_avail) | (tx_ie & tx_space) | rx_overrun | tx_overflow.
REQ-026 SHALL report the RX count as the occupancy 0..FIFO_DEPTH; width is clog2(FIFO_DEPTH)+1 bits, zero-extended to 8 (saturates at 255 for FIFO_DEPTH=256).
REQ-027 SHALL use FIFO pointers that wrap modulo FIFO_DEPTH, and SHALL distinguish full from empty using the count.

Reset
REQ-028 SHALL, on reset, clear both FIFOs and the sticky bits, set control to 0, dout to 0x00, tx_data to 0x00, ena_tx to 0, and the FSM to IDLE; irq is therefore 0.
REQ-029 SHALL, on reset mid-transmission, abort only the bridge state; a byte already handed to the UART is not recalled.

Structure
REQ-030 SHALL keep register addresses, status/control bit indices and FSM state encodings in shared package acia_pkg.
REQ-031 SHALL implement each FIFO as one instance of sub-module sync_fifo (parameterised depth/width, push/pop/full/empty/count); two instances are used.

Verification
REQ-032 SHALL cover: write 0x41,0x42,0x43 to addr0 with tx_busy held low for 2 cycles after each ena_tx -> three ena_tx pulses carrying 0x41,0x42,0x43 in order, each separated by at least 3 cycles.
REQ-033 SHALL cover: 17 rx_rdy pulses with FIFO_DEPTH=16 -> addr3 reads 16, status bit2=1, 16 addr0 reads return the first 16 bytes, then an addr0 read returns 0x00.
REQ-034 SHALL cover: rx_rdy on a full RX FIFO in the same cycle as an addr0 read -> no overrun and count stays 16.
REQ-035 SHALL cover: rx_ie=1 with one byte received -> irq=1; after an addr0 read, irq=0 next cycle.
REQ-036 SHALL cover: 17 TX writes with tx_busy stuck high -> status bit4=1; an addr1 write of 0x10 clears it.
REQ-037 SHALL cover: reset asserted while the FSM is in WAIT with 5 bytes queued -> all outputs at reset values immediately and no further ena_tx.
